// File: rtl/instruction_fetch_pkg.sv
// Shared widths, reset default and fetch-entry layout for the instruction fetch unit.
package instruction_fetch_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam int unsigned     INST_BYTES       = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO of {pc, inst} entries with flush.
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop frees the slot in the same edge, so a full buffer still accepts a push.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PTR_W'(1);
            if (pop_ok)  rd_d = rd_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_q] <= push_entry;
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, issue logic and redirect handling in front of fetch_buffer.
// IMEM_SYNC_READ_EN selects a one-cycle-latency memory with a single tracked in-flight read.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             misalign_q, misalign_d;
    logic             pop, push, issue, room, inflight;
    logic             empty, full;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     push_entry, head;

    assign pop       = inst_valid & inst_ready;
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    // With no read outstanding, buffer fullness alone decides whether there is room.
    assign room      = inflight ? (occupancy < (CNT_W+1)'(DEPTH)) : ~full;
    assign issue     = ~rst & ~redirect_valid & (room | pop);

`ifdef IMEM_SYNC_READ_EN
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;

    assign inflight   = inflight_q;
    // A redirect in the response cycle kills the outstanding read.
    assign push       = inflight_q & ~redirect_valid & ~rst;
    assign push_entry = '{pc: inflight_pc_q, inst: imem_data};

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) inflight_q <= 1'b0;
        else                       inflight_q <= issue;
        if (issue) inflight_pc_q <= fetch_pc_q;
    end
`else
    assign inflight   = 1'b0;
    assign push       = issue;
    assign push_entry = '{pc: fetch_pc_q, inst: imem_data};
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
        if (redirect_valid)  fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        else if (issue)      fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    assign imem_addr    = fetch_pc_q;
    assign imem_req     = issue;
    assign inst_valid   = ~empty;
    assign inst_out     = empty ? '0 : head.inst;
    assign inst_pc      = empty ? '0 : head.pc;
    assign misalign_err = misalign_q;

endmodule
